// File: rtl/lc3_mc_core_if.sv
// Memory bus between the LC-3 multicycle core and its memory.
// The core (master) holds a request until the memory (slave) accepts it with mem_ready.
interface lc3_mc_core_if #(
    parameter int ADDR_W = 16
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/lc3_mc_core.sv
// Multicycle LC-3 subset core: FETCH/DECODE/EXEC/MEM/HALT over a single
// request/ready memory bus, with TRAP-based character output and halt.
module lc3_mc_core #(
    parameter int          ADDR_W   = 16,
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter logic [7:0]  OUT_VEC  = 8'h21,
    parameter logic [7:0]  HALT_VEC = 8'h25
) (
    input  logic          clock,
    input  logic          reset,
    lc3_mc_core_if.master bus,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic          halted,
    output logic          illegal
);

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [ADDR_W-1:0] PC_INIT = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] PC_ONE  = 1;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALT} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] pc, ea;
    logic [15:0]       ir;
    logic [2:0]        cc;
    logic [15:0]       rf [8];

    logic [3:0]  opcode;
    logic [2:0]  dr;
    logic [15:0] sr1_val, alu_b, alu_res, sext9, ea_sum;
    logic        br_taken, is_illegal, mem_req_c;

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15])
            return 3'b100;
        else if (v == 16'h0000)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    // Instruction field decode, ALU and effective-address arithmetic
    always_comb begin
        opcode     = ir[15:12];
        dr         = ir[11:9];
        sr1_val    = rf[ir[8:6]];
        alu_b      = ir[5] ? {{11{ir[4]}}, ir[4:0]} : rf[ir[2:0]];
        sext9      = {{7{ir[8]}}, ir[8:0]};
        ea_sum     = 16'(pc) + sext9;
        br_taken   = |(ir[11:9] & cc);
        is_illegal = opcode inside {4'b1000, 4'b1101, 4'b0100, 4'b0110,
                                    4'b0111, 4'b1010, 4'b1011};
        alu_res    = 16'h0000;
        case (opcode)
            OP_ADD:  alu_res = sr1_val + alu_b;
            OP_AND:  alu_res = sr1_val & alu_b;
            OP_NOT:  alu_res = ~sr1_val;
            default: alu_res = 16'h0000;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= next_state;
    end

    // Next state and bus drive; reset gates mem_req so a pending transfer drops at once
    always_comb begin
        next_state    = state;
        mem_req_c     = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = pc;
        bus.mem_wdata = rf[dr];
        case (state)
            FETCH: begin
                mem_req_c = 1'b1;
                if (bus.mem_ready)
                    next_state = DECODE;
            end
            DECODE: next_state = EXEC;
            EXEC: begin
                if (opcode == OP_LD || opcode == OP_ST)
                    next_state = MEM;
                else if (opcode == OP_TRAP && ir[7:0] == HALT_VEC)
                    next_state = HALT;
                else if (is_illegal)
                    next_state = HALT;
                else
                    next_state = FETCH;
            end
            MEM: begin
                mem_req_c    = 1'b1;
                bus.mem_we   = (opcode == OP_ST);
                bus.mem_addr = ea;
                if (bus.mem_ready)
                    next_state = FETCH;
            end
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
        bus.mem_req = mem_req_c & ~reset;
        halted      = (state == HALT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc        <= PC_INIT;
            ea        <= '0;
            ir        <= 16'h0000;
            cc        <= 3'b010;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            illegal   <= 1'b0;
            for (int i = 0; i < 8; i++)
                rf[i] <= 16'h0000;
        end else begin
            out_valid <= 1'b0;
            case (state)
                FETCH: begin
                    if (bus.mem_ready) begin
                        ir <= bus.mem_rdata;
                        pc <= pc + PC_ONE;
                    end
                end
                EXEC: begin
                    case (opcode)
                        OP_ADD, OP_AND, OP_NOT: begin
                            rf[dr] <= alu_res;
                            cc     <= cc_of(alu_res);
                        end
                        OP_BR: begin
                            if (br_taken)
                                pc <= ea_sum[ADDR_W-1:0];
                        end
                        OP_JMP: pc <= sr1_val[ADDR_W-1:0];
                        OP_LEA: rf[dr] <= 16'(ea_sum[ADDR_W-1:0]);
                        OP_LD, OP_ST: ea <= ea_sum[ADDR_W-1:0];
                        OP_TRAP: begin
                            if (ir[7:0] == OUT_VEC) begin
                                out_valid <= 1'b1;
                                out_data  <= rf[0][7:0];
                            end
                        end
                        default: illegal <= 1'b1;
                    endcase
                end
                MEM: begin
                    if (bus.mem_ready && opcode == OP_LD) begin
                        rf[dr] <= bus.mem_rdata;
                        cc     <= cc_of(bus.mem_rdata);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mc_core.sv
// Self-checking bench for lc3_mc_core: a table of ALU/LEA vectors plus
// hand-written sequences for wait states, LD/ST, TRAP, branches, illegal and reset.
module tb_lc3_mc_core;

    logic       clock = 1'b0;
    logic       reset;
    logic       ready_en;
    logic       out_valid, halted, illegal;
    logic [7:0] out_data;
    logic       out_valid12, halted12, illegal12;
    logic [7:0] out_data12;

    logic [15:0] mem [0:65535];
    int          wr_count;
    logic [15:0] wr_addr, wr_data;
    int          checks;
    int          errors;

    always #5 clock = ~clock;

    lc3_mc_core_if #(.ADDR_W(16)) bus ();
    lc3_mc_core_if #(.ADDR_W(12)) bus12 ();

    assign bus.mem_rdata   = mem[bus.mem_addr];
    assign bus.mem_ready   = ready_en;
    assign bus12.mem_rdata = 16'h0000;
    assign bus12.mem_ready = 1'b1;

    lc3_mc_core dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .out_valid (out_valid),
        .out_data  (out_data),
        .halted    (halted),
        .illegal   (illegal)
    );

    lc3_mc_core #(.ADDR_W(12), .RESET_PC(16'h0FFF)) dut12 (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus12),
        .out_valid (out_valid12),
        .out_data  (out_data12),
        .halted    (halted12),
        .illegal   (illegal12)
    );

    // Records completed store transfers seen on the bus
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_count <= 0;
            wr_addr  <= 16'h0000;
            wr_data  <= 16'h0000;
        end else if (bus.mem_req && bus.mem_we && bus.mem_ready) begin
            wr_count <= wr_count + 1;
            wr_addr  <= bus.mem_addr;
            wr_data  <= bus.mem_wdata;
        end
    end

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  dr;
        logic [15:0] val;
        logic [2:0]  cc;
    } vec_t;

    vec_t vecs [10];

    task automatic check_output(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic hold_reset();
        reset    = 1'b1;
        ready_en = 1'b1;
        for (int i = 0; i < 65536; i++)
            mem[i] = 16'h0000;
    endtask

    task automatic apply_stimulus();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int pulses;
        int req_in_halt;
        logic [15:0] pulse_data;
        logic [15:0] br_pc [5];

        checks = 0;
        errors = 0;

        vecs[0] = '{16'h5020, 3'd0, 16'h0000, 3'b010};
        vecs[1] = '{16'h1025, 3'd0, 16'h0005, 3'b001};
        vecs[2] = '{16'h103A, 3'd0, 16'hFFFF, 3'b100};
        vecs[3] = '{16'h923F, 3'd1, 16'h0000, 3'b010};
        vecs[4] = '{16'h1400, 3'd2, 16'hFFFE, 3'b100};
        vecs[5] = '{16'h56AF, 3'd3, 16'h000E, 3'b001};
        vecs[6] = '{16'h1EC2, 3'd7, 16'h000C, 3'b001};
        vecs[7] = '{16'h59C3, 3'd4, 16'h000C, 3'b001};
        vecs[8] = '{16'hEBFE, 3'd5, 16'h3007, 3'b001};
        vecs[9] = '{16'h9D3F, 3'd6, 16'hFFF3, 3'b100};

        // Reset values and first fetch
        hold_reset();
        for (int i = 0; i < 10; i++)
            mem[16'h3000 + i] = vecs[i].instr;
        repeat (2) @(negedge clock);
        check_output("rst_pc", dut.pc, 16'h3000);
        check_output("rst_cc", 16'(dut.cc), 16'h0002);
        check_output("rst_ir", dut.ir, 16'h0000);
        check_output("rst_req", 16'(bus.mem_req), 16'h0000);
        check_output("rst_flags", {12'h000, out_valid, halted, illegal, 1'b0}, 16'h0000);
        check_output("rst_out_data", 16'(out_data), 16'h0000);
        reset = 1'b0;
        #1;
        check_output("first_req", 16'(bus.mem_req), 16'h0001);
        check_output("first_addr", bus.mem_addr, 16'h3000);
        check_output("aw12_first_addr", 16'(bus12.mem_addr), 16'h0FFF);

        // Table-driven ALU/LEA program, each instruction three cycles
        for (int i = 0; i < 10; i++) begin
            step(3);
            check_output($sformatf("v%0d_reg", i), dut.rf[vecs[i].dr], vecs[i].val);
            check_output($sformatf("v%0d_cc", i), 16'(dut.cc), 16'(vecs[i].cc));
            check_output($sformatf("v%0d_fetch_addr", i), bus.mem_addr, 16'h3001 + 16'(i));
            if (i == 0)
                check_output("aw12_wrap_addr", 16'(bus12.mem_addr), 16'h0000);
        end

        // Fetch with three wait cycles
        hold_reset();
        mem[16'h3000] = 16'h1025;
        ready_en = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_output($sformatf("wait%0d_addr", i), bus.mem_addr, 16'h3000);
            check_output($sformatf("wait%0d_req", i), 16'(bus.mem_req), 16'h0001);
        end
        check_output("wait_ir_held", dut.ir, 16'h0000);
        ready_en = 1'b1;
        step(1);
        check_output("wait_ir", dut.ir, 16'h1025);
        check_output("wait_pc", dut.pc, 16'h3001);

        // LD then ST
        hold_reset();
        mem[16'h3000] = 16'h2202;
        mem[16'h3001] = 16'h33FF;
        mem[16'h3003] = 16'h8000;
        apply_stimulus();
        step(3);
        check_output("ld_addr", bus.mem_addr, 16'h3003);
        check_output("ld_we", 16'(bus.mem_we), 16'h0000);
        step(1);
        check_output("ld_r1", dut.rf[1], 16'h8000);
        check_output("ld_cc", 16'(dut.cc), 16'h0004);
        step(3);
        check_output("st_we", 16'(bus.mem_we), 16'h0001);
        check_output("st_addr", bus.mem_addr, 16'h3001);
        check_output("st_wdata", bus.mem_wdata, 16'h8000);
        step(1);
        check_output("st_count", 16'(wr_count), 16'h0001);
        check_output("st_wr_addr", wr_addr, 16'h3001);
        check_output("st_wr_data", wr_data, 16'h8000);
        check_output("st_next_fetch", bus.mem_addr, 16'h3002);

        // TRAP OUT then TRAP HALT
        hold_reset();
        mem[16'h3000] = 16'h2003;
        mem[16'h3001] = 16'hF021;
        mem[16'h3002] = 16'hF025;
        mem[16'h3004] = 16'h0041;
        apply_stimulus();
        pulses      = 0;
        req_in_halt = 0;
        pulse_data  = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (out_valid) begin
                pulses++;
                pulse_data = 16'(out_data);
            end
            if (halted && bus.mem_req)
                req_in_halt++;
        end
        check_output("trap_pulses", 16'(pulses), 16'h0001);
        check_output("trap_char", pulse_data, 16'h0041);
        check_output("trap_out_hold", 16'(out_data), 16'h0041);
        check_output("trap_halted", 16'(halted), 16'h0001);
        check_output("trap_req_in_halt", 16'(req_in_halt), 16'h0000);
        check_output("trap_pc_frozen", dut.pc, 16'h3003);
        check_output("trap_not_illegal", 16'(illegal), 16'h0000);

        // Branches, LEA and JMP
        hold_reset();
        mem[16'h3000] = 16'h0805;
        mem[16'h3001] = 16'h0402;
        mem[16'h3004] = 16'h0001;
        mem[16'h3005] = 16'hE7FA;
        mem[16'h3006] = 16'hC0C0;
        br_pc[0] = 16'h3001;
        br_pc[1] = 16'h3004;
        br_pc[2] = 16'h3005;
        br_pc[3] = 16'h3006;
        br_pc[4] = 16'h3000;
        apply_stimulus();
        for (int i = 0; i < 5; i++) begin
            step(3);
            check_output($sformatf("br%0d_pc", i), dut.pc, br_pc[i]);
        end
        check_output("br_lea_r3", dut.rf[3], 16'h3000);

        // Illegal opcode halts the core
        hold_reset();
        mem[16'h3000] = 16'hD000;
        apply_stimulus();
        step(3);
        check_output("ill_flag", 16'(illegal), 16'h0001);
        check_output("ill_halted", 16'(halted), 16'h0001);
        check_output("ill_req", 16'(bus.mem_req), 16'h0000);
        step(2);
        check_output("ill_pc_frozen", dut.pc, 16'h3001);

        // Reset asserted during a stalled fetch
        hold_reset();
        mem[16'h3000] = 16'h1025;
        mem[16'h3001] = 16'h1025;
        apply_stimulus();
        check_output("rst_clears_illegal", 16'(illegal), 16'h0000);
        step(3);
        ready_en = 1'b0;
        step(2);
        check_output("mid_req_before", 16'(bus.mem_req), 16'h0001);
        check_output("mid_pc_before", dut.pc, 16'h3001);
        reset = 1'b1;
        #1;
        check_output("mid_req_dropped", 16'(bus.mem_req), 16'h0000);
        check_output("mid_pc_reset", dut.pc, 16'h3000);
        check_output("mid_r0_cleared", dut.rf[0], 16'h0000);
        @(negedge clock);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_mc_core.md
LC3_MC_CORE -- requirements
Module: lc3_mc_core

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width and PC width; allowed range 9..16.
REQ-002 Parameter RESET_PC, default 16'h3000, PC value loaded on reset and truncated to ADDR_W.
REQ-003 Parameter OUT_VEC, default 8'h21, TRAP vector that emits R0[7:0].
REQ-004 Parameter HALT_VEC, default 8'h25, TRAP vector that halts the core.
REQ-005 clock  in  1  single clock, rising-edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 mem_req  out  1  memory request, held until accepted.
REQ-008 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-009 mem_addr  out  ADDR_W  request address.
REQ-010 mem_wdata  out  16  write data.
REQ-011 mem_rdata  in  16  read data, sampled on the acceptance cycle.
REQ-012 mem_ready  in  1  acceptance: a transfer completes on the edge where mem_req=1 and mem_ready=1.
REQ-013 out_valid  out  1  one-cycle pulse carrying the TRAP OUT character.
REQ-014 out_data  out  8  character; holds its value between pulses.
REQ-015 halted  out  1  core stopped by HALT or an illegal opcode.
REQ-016 illegal  out  1  sticky flag, set when an unsupported opcode halts the core.

Function
REQ-017 FSM states: FETCH, DECODE, EXEC, MEM, HALT; exactly one state per cycle.
REQ-018 FETCH:
  - drive mem_req=1, mem_we=0, mem_addr=PC;
  - on acceptance: IR<=mem_rdata, PC<=PC+1 modulo 2^ADDR_W, go to DECODE.
REQ-019 DECODE: one cycle, no bus activity, go to EXEC.
REQ-020 EXEC executes in one cycle:
  - ADD/AND, register or imm5 sign-extended: DR<=result, CC updated;
  - NOT: DR<=~SR1, CC updated;
  - BR: PC<=PC+SEXT(off9) when (n&N)|(z&Z)|(p&P); nzp=000 never branches;
  - JMP/RET: PC<=BaseR;
  - LEA: DR<=PC+SEXT(off9); CC unchanged;
  - LD/ST: compute EA=PC+SEXT(off9), go to MEM;
  - all other listed cases return to FETCH.
REQ-021 TRAP in EXEC:
  - vector OUT_VEC: out_data<=R0[7:0], out_valid=1 for exactly one cycle, go to FETCH;
  - vector HALT_VEC: go to HALT;
  - any other vector: no-op, go to FETCH.
REQ-022 MEM:
  - LD: mem_req=1, mem_we=0, mem_addr=EA; on acceptance DR<=mem_rdata, CC updated, go to FETCH;
  - ST: mem_req=1, mem_we=1, mem_addr=EA, mem_wdata=SR; on acceptance go to FETCH.
REQ-023 Handshake: mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req=1 and unaccepted; mem_ready with mem_req=0 is ignored; a zero-wait memory (mem_ready tied 1) is legal.
REQ-024 Latency with zero wait states: ALU/BR/JMP/LEA/TRAP take 3 cycles; LD/ST take 4 cycles; each wait cycle adds 1.
REQ-025 CC rule: N=result[15], Z=(result==0), P=otherwise; exactly one bit set.
REQ-026 Arithmetic: 16-bit, wraps modulo 2^16; effective addresses and PC values are truncated to ADDR_W bits.
REQ-027 Illegal opcodes (RTI, reserved 1101, JSR, LDR, STR, LDI, STI): set illegal=1 and go to HALT.
REQ-028 HALT:
  - mem_req=0, halted=1, register state frozen;
  - exit only through reset.
REQ-029 Register file: 8x16, two combinational reads, one synchronous write in EXEC or MEM only; R7 is ordinary.

Reset
REQ-030 While reset=1, asynchronously:
  - PC=RESET_PC, R0..R7=0, IR=0, CC=010 (Z);
  - state=FETCH, mem_req=0, mem_we=0, out_valid=0, out_data=0, halted=0, illegal=0.
REQ-031 Reset asserted mid-transfer SHALL drop mem_req in the same cycle; the pending transfer is abandoned with no register or PC update.
REQ-032 After reset deasserts, the first mem_req is raised in the first FETCH cycle, with mem_addr=RESET_PC.

Verification
REQ-033 Zero-wait memory, program AND R0,R0,#0 / ADD R0,R0,#5 / ADD R0,R0,#-6 -> R0=16'hFFFF, CC=100, 9 cycles total.
REQ-034 mem_ready low for 3 cycles during fetch -> mem_addr stays 3000 throughout; IR is captured on the 4th cycle; PC=3001.
REQ-035 LD R1 with off9=+2 at 3000, memory[3003]=8000 -> read at 3003, R1=8000, CC=100; ST R1 with off9=-1 at 3001 writes 8000 to 3001.
REQ-036 R0=0041, TRAP x21 then TRAP x25 -> one out_valid pulse with out_data=41, then halted=1 and mem_req stuck at 0.
REQ-037 ADDR_W=12, RESET_PC=FFF -> first fetch at FFF, second fetch at 000.
REQ-038 Opcode 1101 fetched -> illegal=1, halted=1; reset asserted while mem_req=1 -> mem_req=0 immediately, PC=RESET_PC.
